// File: rtl/dcache_defs_pkg.sv
// dcache_defs: shared geometry and FSM encodings for the data cache
package dcache_defs;
    localparam int TAG_W        = 25;
    localparam int INDEX_W      = 3;
    localparam int WORD_W       = 2;
    localparam int LINE_W       = 128;
    localparam int BLOCK_ADDR_W = 28;
    localparam int LINES        = 1 << INDEX_W;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage with async read, sync word write and line fill
module dcache_line_array
    import dcache_defs::*;
(
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [INDEX_W-1:0] index,
    output logic               valid,
    output logic               dirty,
    output logic [TAG_W-1:0]   tag,
    output logic [LINE_W-1:0]  line,
    input  logic               word_we,
    input  logic [WORD_W-1:0]  word_sel,
    input  logic [31:0]        word_data,
    input  logic               fill_we,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [LINE_W-1:0]  fill_line
);
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_q[index];
    assign line  = data_q[index];
    // status bits: a fill makes the line valid and clean, a store hit marks it dirty
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end
    // tag and data contents survive reset; only the status bits are cleared
    always_ff @(posedge CLOCK) begin
        if (fill_we) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_line;
        end else if (word_we) begin
            data_q[index][{word_sel, 5'd0} +: 32] <= word_data;
        end
    end
endmodule

// File: rtl/data_cache_controller.sv
// data_cache_controller: direct-mapped write-back write-allocate cache FSM, hit logic and memory handshake
module data_cache_controller
    import dcache_defs::*;
(
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [31:0]             ADDRESS,
    input  logic [31:0]             WRITEDATA,
    output logic [31:0]             READDATA,
    output logic                    BUSYWAIT,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
    output logic [LINE_W-1:0]       MEM_WRITEDATA,
    input  logic [LINE_W-1:0]       MEM_READDATA,
    input  logic                    MEM_BUSYWAIT
);
    state_t             state, next;
    logic               access, hit, valid, dirty, word_we, fill_we;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line;
    logic [INDEX_W-1:0] index;
    logic [WORD_W-1:0]  word;
    logic               unused_byte_offset;
    assign unused_byte_offset = ^ADDRESS[1:0];
    assign index    = ADDRESS[6:4];
    assign word     = ADDRESS[3:2];
    assign access   = READ ^ WRITE;
    assign hit      = valid && (line_tag == ADDRESS[31:7]);
    assign word_we  = (state == IDLE) && WRITE && !READ && hit;
    assign fill_we  = (state == ALLOCATE) && !MEM_BUSYWAIT;
    assign READDATA = hit ? line[{word, 5'd0} +: 32] : '0;
    assign BUSYWAIT = RESET && access && (!hit || state != IDLE);
    dcache_line_array u_array (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .index     (index),
        .valid     (valid),
        .dirty     (dirty),
        .tag       (line_tag),
        .line      (line),
        .word_we   (word_we),
        .word_sel  (word),
        .word_data (WRITEDATA),
        .fill_we   (fill_we),
        .fill_tag  (ADDRESS[31:7]),
        .fill_line (MEM_READDATA)
    );
    // state register; reset abandons any in-flight memory request
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= next;
    end
    // next state and memory request outputs; a request completes on the first edge with MEM_BUSYWAIT low
    always_comb begin
        next          = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        unique case (state)
            IDLE: begin
                if (access && !hit) next = dirty ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {line_tag, index};
                MEM_WRITEDATA = line;
                if (!MEM_BUSYWAIT) next = access ? ALLOCATE : IDLE;
            end
            ALLOCATE: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
                if (!MEM_BUSYWAIT) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller: directed checks of the data cache against a 3-cycle memory model
module tb_data_cache_controller;
    localparam int LAT = 3;
    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          READ, WRITE;
    logic [31:0]   ADDRESS, WRITEDATA, READDATA;
    logic          BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]   MEM_ADDRESS;
    logic [127:0]  MEM_WRITEDATA, MEM_READDATA;
    int            passed, total;
    int            cnt, both_cnt, wr_cycles, rd_done;
    logic [27:0]   last_rd, last_wr;
    logic [7:0]    op_log;
    bit [63:0]     wvalid;
    logic [127:0]  wbuf [64];
    int            st, w0;

    data_cache_controller dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLOCK = ~CLOCK;

    // untouched blocks return a recognisable pattern; block 2 returns the word-select line
    function automatic logic [127:0] pat(input logic [27:0] b);
        return (b == 28'h2) ? 128'h33333333_22222222_11111111_00000000
                            : {b[15:0], 16'h3, b[15:0], 16'h2, b[15:0], 16'h1, b[15:0], 16'h0};
    endfunction

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < LAT - 1);
    assign MEM_READDATA = wvalid[MEM_ADDRESS[5:0]] ? wbuf[MEM_ADDRESS[5:0]] : pat(MEM_ADDRESS);

    // memory model: busy for LAT-1 cycles of a held request, completes on the next edge
    always @(posedge CLOCK) begin
        if (MEM_READ && MEM_WRITE) both_cnt <= both_cnt + 1;
        if (MEM_WRITE) wr_cycles <= wr_cycles + 1;
        if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
            cnt    <= 0;
            op_log <= {op_log[5:0], MEM_WRITE ? 2'd1 : 2'd2};
            if (MEM_WRITE) begin
                wbuf[MEM_ADDRESS[5:0]]   <= MEM_WRITEDATA;
                wvalid[MEM_ADDRESS[5:0]] <= 1'b1;
                last_wr                  <= MEM_ADDRESS;
            end else begin
                last_rd <= MEM_ADDRESS;
                rd_done <= rd_done + 1;
            end
        end else begin
            cnt <= (MEM_READ || MEM_WRITE) ? cnt + 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_free(output int stalls);
        stalls = 0;
        #1;
        while (BUSYWAIT && stalls < 50) begin
            @(posedge CLOCK);
            #1;
            stalls++;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_data, input int exp_st, input string tag);
        int s;
        READ = 1'b1; WRITE = 1'b0; ADDRESS = a;
        wait_free(s);
        chk({tag, "_stall"}, 128'(s), 128'(exp_st));
        chk({tag, "_data"}, 128'(READDATA), 128'(exp_data));
        @(posedge CLOCK); #1;
        READ = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int exp_st, input string tag);
        int s;
        READ = 1'b0; WRITE = 1'b1; ADDRESS = a; WRITEDATA = d;
        wait_free(s);
        chk({tag, "_stall"}, 128'(s), 128'(exp_st));
        @(posedge CLOCK); #1;
        WRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'h40; WRITEDATA = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        chk("rst_busywait", 128'(BUSYWAIT), 128'd0);
        chk("rst_mem_read", 128'(MEM_READ), 128'd0);
        chk("rst_mem_write", 128'(MEM_WRITE), 128'd0);
        chk("rst_mem_address", 128'(MEM_ADDRESS), 128'd0);
        chk("rst_mem_writedata", MEM_WRITEDATA, 128'd0);
        chk("rst_readdata", 128'(READDATA), 128'd0);
        RESET = 1'b1;
        #1;
        chk("cold_miss_busy", 128'(BUSYWAIT), 128'd1);
        @(posedge CLOCK); #1;
        chk("alloc_mem_read", 128'(MEM_READ), 128'd1);
        chk("alloc_mem_address", 128'(MEM_ADDRESS), 128'h4);
        RESET = 1'b0;
        #1;
        chk("midreset_mem_read", 128'(MEM_READ), 128'd0);
        chk("midreset_busywait", 128'(BUSYWAIT), 128'd0);
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        wait_free(st);
        chk("cold_stall", 128'(st), 128'(LAT + 1));
        chk("cold_data", 128'(READDATA), 128'h0004_0000);
        chk("cold_rd_addr", 128'(last_rd), 128'h4);
        chk("cold_rd_count", 128'(rd_done), 128'd1);
        @(posedge CLOCK); #1;
        READ = 1'b0;

        wr(32'h44, 32'hDEADBEEF, 0, "write_hit");
        rd(32'h44, 32'hDEADBEEF, 0, "read_after_write");
        rd(32'h40, 32'h0004_0000, 0, "neighbour_word");

        READ = 1'b1; ADDRESS = 32'hC4;
        #1;
        chk("dirty_miss_busy", 128'(BUSYWAIT), 128'd1);
        @(posedge CLOCK); #1;
        chk("wb_mem_write", 128'(MEM_WRITE), 128'd1);
        chk("wb_mem_read", 128'(MEM_READ), 128'd0);
        chk("wb_mem_address", 128'(MEM_ADDRESS), 128'h4);
        chk("wb_mem_writedata", MEM_WRITEDATA, 128'h00040003_00040002_DEADBEEF_00040000);
        wait_free(st);
        chk("dirty_stall_rest", 128'(st), 128'(2 * LAT));
        chk("dirty_data", 128'(READDATA), 128'h000C_0001);
        chk("dirty_op_order", 128'(op_log[3:0]), 128'b0110);
        chk("dirty_rd_addr", 128'(last_rd), 128'hC);
        chk("dirty_wr_addr", 128'(last_wr), 128'h4);
        @(posedge CLOCK); #1;
        READ = 1'b0;

        w0 = wr_cycles;
        rd(32'h44, 32'hDEADBEEF, LAT + 1, "clean_evict");
        chk("clean_no_write", 128'(wr_cycles), 128'(w0));
        chk("clean_op", 128'(op_log[1:0]), 128'd2);

        READ = 1'b1; WRITE = 1'b1; ADDRESS = 32'h44; WRITEDATA = 32'h12345678;
        #1;
        chk("illegal_busywait", 128'(BUSYWAIT), 128'd0);
        chk("illegal_mem_read", 128'(MEM_READ), 128'd0);
        chk("illegal_mem_write", 128'(MEM_WRITE), 128'd0);
        repeat (2) @(posedge CLOCK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
        rd(32'h44, 32'hDEADBEEF, 0, "illegal_unchanged");
        rd(32'hC4, 32'h000C_0001, LAT + 1, "illegal_stayed_clean");
        chk("illegal_no_write", 128'(wr_cycles), 128'(w0));

        rd(32'h20, 32'h00000000, LAT + 1, "word0");
        rd(32'h24, 32'h11111111, 0, "word1");
        rd(32'h28, 32'h22222222, 0, "word2");
        rd(32'h2C, 32'h33333333, 0, "word3");

        wr(32'h54, 32'hCAFEF00D, LAT + 1, "write_miss");
        rd(32'h54, 32'hCAFEF00D, 0, "write_miss_read");

        READ = 1'b1; ADDRESS = 32'h1C0;
        @(posedge CLOCK); #1;
        READ = 1'b0;
        repeat (4) @(posedge CLOCK);
        #1;
        chk("drop_mem_read", 128'(MEM_READ), 128'd0);
        chk("drop_mem_write", 128'(MEM_WRITE), 128'd0);
        rd(32'h1C0, 32'h001C_0000, 0, "drop_filled");

        chk("never_both", 128'(both_cnt), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
